// File: rtl/geogenius_pkg.sv
// Shared types for the multi-mode quiz engine: state encoding and the
// difficulty-mode timeout scaling.
package geogenius_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARA       = 4'h1,
      ESPERA        = 4'h2,
      REGISTRA      = 4'h3,
      COMPARA       = 4'h4,
      MOSTRA_ACERTO = 4'h5,
      MOSTRA_ERRO   = 4'h6,
      PROXIMA       = 4'h7,
      FIM_ACERTO    = 4'hA,
      FIM_ERRO      = 4'hE,
      FIM_TIMEOUT   = 4'hF
   } estado_t;

   function automatic int divisor(input logic [1:0] modo);
      return 1 << modo;
   endfunction

   // Response window in cycles for a mode; harder modes never drop below one cycle.
   function automatic int t_resp(input int t0, input logic [1:0] modo);
      int t;
      t = t0 / divisor(modo);
      return (t < 1) ? 1 : t;
   endfunction

endpackage

// File: rtl/geogenius_rom_respostas.sv
// Answer table: the index of the correct button for each round.
// Round i expects button (i mod N_BOTOES).
module geogenius_rom_respostas #(
   parameter int N_BOTOES  = 8,
   parameter int N_RODADAS = 16
) (
   input  logic [$clog2(N_RODADAS)-1:0] rodada,
   output logic [$clog2(N_BOTOES)-1:0]  resposta
);

   localparam int DW = $clog2(N_BOTOES);

   logic [DW-1:0] tabela [N_RODADAS];

   generate
      for (genvar gi = 0; gi < N_RODADAS; gi++) begin : g_tabela
         assign tabela[gi] = DW'(gi % N_BOTOES);
      end
   endgenerate

   assign resposta = tabela[rodada];

endmodule

// File: rtl/geogenius_multimodo.sv
// Round-based quiz engine: one-hot press detection, answer comparison,
// lives/score bookkeeping, per-mode response timeout and result hold time.
module geogenius_multimodo
   import geogenius_pkg::*;
#(
   parameter int N_BOTOES    = 8,
   parameter int N_RODADAS   = 16,
   parameter int N_VIDAS     = 3,
   parameter int T_RESP_0    = 5000,
   parameter int T_RESULTADO = 1000
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           jogar,
   input  logic [N_BOTOES-1:0]            botoes,
   input  logic [1:0]                     dificuldade,
   output logic                           acertou,
   output logic                           errou,
   output logic                           timeout,
   output logic                           pronto,
   output logic [N_BOTOES-1:0]            leds,
   output logic [$clog2(N_RODADAS+1)-1:0] score,
   output logic [2:0]                     vidas,
   output logic [$clog2(N_RODADAS)-1:0]   rodada,
   output logic [3:0]                     db_estado
);

   localparam int SW      = $clog2(N_RODADAS + 1);
   localparam int RW      = $clog2(N_RODADAS);
   localparam int AW      = $clog2(N_BOTOES);
   localparam int TMAX    = (T_RESP_0 > T_RESULTADO) ? T_RESP_0 : T_RESULTADO;
   localparam int TW      = $clog2(TMAX + 1);
   localparam int LIM0    = t_resp(T_RESP_0, 2'd0) - 1;
   localparam int LIM1    = t_resp(T_RESP_0, 2'd1) - 1;
   localparam int LIM2    = t_resp(T_RESP_0, 2'd2) - 1;
   localparam int LIM3    = t_resp(T_RESP_0, 2'd3) - 1;
   localparam int LIM_RES = T_RESULTADO - 1;
   localparam int META    = (N_RODADAS + 1) / 2;

   estado_t              estado_reg, estado_next;
   logic [1:0]           modo_reg;
   logic [TW-1:0]        timer_reg;
   logic [N_BOTOES-1:0]  prev_reg;
   logic [N_BOTOES-1:0]  captura_reg;
   logic [N_BOTOES-1:0]  jogada_reg;
   logic [SW-1:0]        score_reg;
   logic [2:0]           vidas_reg;
   logic [RW-1:0]        rodada_reg;
   logic                 por_timeout_reg;

   logic                 one_hot, limpo, press;
   logic [TW-1:0]        limite_resp;
   logic                 fim_resp, fim_res, acerto, ultima;
   logic [AW-1:0]        resposta;
   logic [N_BOTOES-1:0]  esperado;

   geogenius_rom_respostas #(
      .N_BOTOES  (N_BOTOES),
      .N_RODADAS (N_RODADAS)
   ) u_rom (
      .rodada   (rodada_reg),
      .resposta (resposta)
   );

   // The edge reference only follows clean (zero or one-hot) vectors, so a
   // multi-hot glitch does not hide the rising edge of the single button that remains.
   assign one_hot  = (botoes != '0) && ((botoes & (botoes - 1'b1)) == '0);
   assign limpo    = (botoes == '0) || one_hot;
   assign press    = one_hot && ((botoes & ~prev_reg) != '0);
   assign fim_resp = (timer_reg == limite_resp);
   assign fim_res  = (timer_reg == TW'(LIM_RES));
   assign esperado = N_BOTOES'(1) << resposta;
   assign acerto   = (jogada_reg == esperado);
   assign ultima   = (rodada_reg == RW'(N_RODADAS - 1));

   always_comb begin
      limite_resp = TW'(LIM0);
      case (modo_reg)
         2'd1:    limite_resp = TW'(LIM1);
         2'd2:    limite_resp = TW'(LIM2);
         2'd3:    limite_resp = TW'(LIM3);
         default: limite_resp = TW'(LIM0);
      endcase
   end

   always_comb begin
      estado_next = estado_reg;
      case (estado_reg)
         INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
            if (jogar) estado_next = PREPARA;
         PREPARA:  estado_next = ESPERA;
         ESPERA: begin
            if (press)         estado_next = REGISTRA;
            else if (fim_resp) estado_next = MOSTRA_ERRO;
         end
         REGISTRA: estado_next = COMPARA;
         COMPARA:  estado_next = acerto ? MOSTRA_ACERTO : MOSTRA_ERRO;
         MOSTRA_ACERTO:
            if (fim_res) estado_next = PROXIMA;
         MOSTRA_ERRO: begin
            if (fim_res) begin
               if (vidas_reg == 3'd0)
                  estado_next = por_timeout_reg ? FIM_TIMEOUT : FIM_ERRO;
               else
                  estado_next = PROXIMA;
            end
         end
         PROXIMA: begin
            if (ultima)
               estado_next = (score_reg >= SW'(META)) ? FIM_ACERTO : FIM_ERRO;
            else if (botoes == '0)
               estado_next = ESPERA;
         end
         default:  estado_next = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_reg      <= INICIAL;
         modo_reg        <= '0;
         timer_reg       <= '0;
         prev_reg        <= '0;
         captura_reg     <= '0;
         jogada_reg      <= '0;
         score_reg       <= '0;
         vidas_reg       <= 3'(N_VIDAS);
         rodada_reg      <= '0;
         por_timeout_reg <= 1'b0;
      end else begin
         estado_reg <= estado_next;
         if (limpo) prev_reg <= botoes;

         // Every state change restarts the timer, so each window starts at zero.
         if (estado_next != estado_reg)
            timer_reg <= '0;
         else if (estado_reg == ESPERA || estado_reg == MOSTRA_ACERTO || estado_reg == MOSTRA_ERRO)
            timer_reg <= timer_reg + 1'b1;

         case (estado_reg)
            PREPARA: begin
               score_reg       <= '0;
               rodada_reg      <= '0;
               vidas_reg       <= 3'(N_VIDAS);
               modo_reg        <= dificuldade;
               jogada_reg      <= '0;
               por_timeout_reg <= 1'b0;
            end
            ESPERA: begin
               if (press) begin
                  captura_reg <= botoes;
               end else if (fim_resp) begin
                  if (vidas_reg != 3'd0) vidas_reg <= vidas_reg - 1'b1;
                  por_timeout_reg <= 1'b1;
                  jogada_reg      <= '0;
               end
            end
            REGISTRA: jogada_reg <= captura_reg;
            COMPARA: begin
               if (acerto) begin
                  if (score_reg != SW'(N_RODADAS)) score_reg <= score_reg + 1'b1;
               end else begin
                  if (vidas_reg != 3'd0) vidas_reg <= vidas_reg - 1'b1;
                  por_timeout_reg <= 1'b0;
               end
            end
            PROXIMA: begin
               if (!ultima && botoes == '0) begin
                  rodada_reg <= rodada_reg + 1'b1;
                  jogada_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign acertou   = (estado_reg == FIM_ACERTO);
   assign errou     = (estado_reg == FIM_ERRO);
   assign timeout   = (estado_reg == FIM_TIMEOUT);
   assign pronto    = acertou || errou || timeout;
   assign leds      = (estado_reg == MOSTRA_ACERTO || estado_reg == MOSTRA_ERRO) ? jogada_reg :
                      (estado_reg == FIM_ACERTO) ? '1 : '0;
   assign score     = score_reg;
   assign vidas     = vidas_reg;
   assign rodada    = rodada_reg;
   assign db_estado = estado_reg;

endmodule
